// File: rtl/ball_scheduler.sv
// Frame-driven motion scheduler for a set of bouncing objects on a 256x128 playfield.
// Per-object state lives in a small register file. The host writes it through a config
// port while the block is idle. Each frame_tick starts a pass that steps one slot per
// cycle. A registered read port lets the renderer fetch position and color at any time.
module ball_scheduler #(
  parameter int NUM_OBJ = 4,
  parameter int X_MAX   = 255,
  parameter int Y_MAX   = 127,
  localparam int IDX_W  = $clog2(NUM_OBJ)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             frame_tick,
  input  logic             cfg_we,
  output logic             cfg_ready,
  input  logic [IDX_W-1:0] cfg_idx,
  input  logic [7:0]       cfg_x,
  input  logic [6:0]       cfg_y,
  input  logic             cfg_vx,
  input  logic             cfg_vy,
  input  logic [11:0]      cfg_color,
  input  logic             cfg_en,
  input  logic [IDX_W-1:0] rd_idx,
  output logic [7:0]       rd_x,
  output logic [6:0]       rd_y,
  output logic [11:0]      rd_color,
  output logic             busy,
  output logic             done,
  output logic             overrun
);

  typedef enum logic [1:0] {
    IDLE,
    UPDATE,
    DONE
  } state_e;

  localparam logic [7:0]       X_LIM    = 8'(X_MAX);
  localparam logic [6:0]       Y_LIM    = 7'(Y_MAX);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_OBJ - 1);

  state_e           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             overrun_q, overrun_d;

  logic [7:0]  x_q     [NUM_OBJ];
  logic [7:0]  x_d     [NUM_OBJ];
  logic [6:0]  y_q     [NUM_OBJ];
  logic [6:0]  y_d     [NUM_OBJ];
  logic        vx_q    [NUM_OBJ];
  logic        vx_d    [NUM_OBJ];
  logic        vy_q    [NUM_OBJ];
  logic        vy_d    [NUM_OBJ];
  logic [11:0] color_q [NUM_OBJ];
  logic [11:0] color_d [NUM_OBJ];
  logic        en_q    [NUM_OBJ];
  logic        en_d    [NUM_OBJ];

  logic [7:0]  rd_x_q, rd_x_d;
  logic [6:0]  rd_y_q, rd_y_d;
  logic [11:0] rd_color_q, rd_color_d;

  logic [7:0]  cfg_x_c;
  logic [6:0]  cfg_y_c;
  logic [7:0]  step_x;
  logic [6:0]  step_y;
  logic        step_vx, step_vy;
  logic        rd_valid;

  // The widening bit keeps the compare meaningful even when the limit is the full range.
  assign cfg_x_c  = ({1'b0, cfg_x} > {1'b0, X_LIM}) ? X_LIM : cfg_x;
  assign cfg_y_c  = ({1'b0, cfg_y} > {1'b0, Y_LIM}) ? Y_LIM : cfg_y;
  assign rd_valid = (32'(rd_idx) < NUM_OBJ);

  assign cfg_ready = (state_q == IDLE);
  assign busy      = (state_q == UPDATE);
  assign done      = (state_q == DONE);
  assign overrun   = overrun_q;
  assign rd_x      = rd_x_q;
  assign rd_y      = rd_y_q;
  assign rd_color  = rd_color_q;

  // Pass sequencing: a tick in IDLE starts a pass; ticks arriving mid-pass only flag overrun.
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    overrun_d = overrun_q;
    case (state_q)
      IDLE: begin
        if (frame_tick) begin
          state_d = UPDATE;
          idx_d   = '0;
        end
      end
      UPDATE: begin
        if (idx_q == LAST_IDX) begin
          state_d = DONE;
          idx_d   = '0;
        end else begin
          idx_d = idx_q + 1'b1;
        end
        if (frame_tick) overrun_d = 1'b1;
      end
      DONE: begin
        state_d = IDLE;
        if (frame_tick) overrun_d = 1'b1;
      end
      default: begin
        state_d = IDLE;
        idx_d   = '0;
      end
    endcase
  end

  // Bounce rule for the slot under idx: move one step, reflecting off either wall without wrapping.
  always_comb begin
    step_x  = x_q[idx_q];
    step_vx = vx_q[idx_q];
    step_y  = y_q[idx_q];
    step_vy = vy_q[idx_q];
    if (vx_q[idx_q]) begin
      if (x_q[idx_q] < X_LIM) begin
        step_x = x_q[idx_q] + 8'd1;
      end else begin
        step_x  = X_LIM - 8'd1;
        step_vx = 1'b0;
      end
    end else begin
      if (x_q[idx_q] != 8'd0) begin
        step_x = x_q[idx_q] - 8'd1;
      end else begin
        step_x  = 8'd1;
        step_vx = 1'b1;
      end
    end
    if (vy_q[idx_q]) begin
      if (y_q[idx_q] < Y_LIM) begin
        step_y = y_q[idx_q] + 7'd1;
      end else begin
        step_y  = Y_LIM - 7'd1;
        step_vy = 1'b0;
      end
    end else begin
      if (y_q[idx_q] != 7'd0) begin
        step_y = y_q[idx_q] - 7'd1;
      end else begin
        step_y  = 7'd1;
        step_vy = 1'b1;
      end
    end
  end

  // Register file update: host writes only in IDLE, the pass steps one enabled slot per cycle.
  always_comb begin
    x_d     = x_q;
    y_d     = y_q;
    vx_d    = vx_q;
    vy_d    = vy_q;
    color_d = color_q;
    en_d    = en_q;
    if ((state_q == IDLE) && cfg_we) begin
      x_d[cfg_idx]     = cfg_x_c;
      y_d[cfg_idx]     = cfg_y_c;
      vx_d[cfg_idx]    = cfg_vx;
      vy_d[cfg_idx]    = cfg_vy;
      color_d[cfg_idx] = cfg_color;
      en_d[cfg_idx]    = cfg_en;
    end
    if ((state_q == UPDATE) && en_q[idx_q]) begin
      x_d[idx_q]     = step_x;
      y_d[idx_q]     = step_y;
      vx_d[idx_q]    = step_vx;
      vy_d[idx_q]    = step_vy;
      color_d[idx_q] = color_q[idx_q] + 12'd1;
    end
  end

  // Renderer read port: look up the addressed slot; out-of-range addresses read as zero.
  always_comb begin
    rd_x_d     = '0;
    rd_y_d     = '0;
    rd_color_d = '0;
    if (rd_valid) begin
      rd_x_d     = x_q[rd_idx];
      rd_y_d     = y_q[rd_idx];
      rd_color_d = color_q[rd_idx];
    end
  end

  // State, register file and read-port flops; reset also aborts any pass in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      idx_q      <= '0;
      overrun_q  <= 1'b0;
      rd_x_q     <= '0;
      rd_y_q     <= '0;
      rd_color_q <= '0;
      for (int i = 0; i < NUM_OBJ; i++) begin
        x_q[i]     <= 8'd1;
        y_q[i]     <= 7'd1;
        vx_q[i]    <= 1'b1;
        vy_q[i]    <= 1'b1;
        color_q[i] <= 12'd0;
        en_q[i]    <= 1'b1;
      end
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      overrun_q  <= overrun_d;
      rd_x_q     <= rd_x_d;
      rd_y_q     <= rd_y_d;
      rd_color_q <= rd_color_d;
      x_q        <= x_d;
      y_q        <= y_d;
      vx_q       <= vx_d;
      vy_q       <= vy_d;
      color_q    <= color_d;
      en_q       <= en_d;
    end
  end

endmodule

// File: tb/tb_ball_scheduler.sv
// Directed bench for ball_scheduler: default instance plus a Y_MAX=100 instance sharing inputs.
module tb_ball_scheduler;

  logic        clk = 1'b0;
  logic        rst;
  logic        frame_tick;
  logic        cfg_we;
  logic [1:0]  cfg_idx;
  logic [7:0]  cfg_x;
  logic [6:0]  cfg_y;
  logic        cfg_vx;
  logic        cfg_vy;
  logic [11:0] cfg_color;
  logic        cfg_en;
  logic [1:0]  rd_idx;

  logic        cfg_ready, busy, done, overrun;
  logic [7:0]  rd_x;
  logic [6:0]  rd_y;
  logic [11:0] rd_color;

  logic        cfg_ready_b, busy_b, done_b, overrun_b;
  logic [7:0]  rd_x_b;
  logic [6:0]  rd_y_b;
  logic [11:0] rd_color_b;

  int tests = 0;
  int fails = 0;

  ball_scheduler #(.NUM_OBJ(4), .X_MAX(255), .Y_MAX(127)) dut (
    .clk(clk), .rst(rst), .frame_tick(frame_tick), .cfg_we(cfg_we), .cfg_ready(cfg_ready),
    .cfg_idx(cfg_idx), .cfg_x(cfg_x), .cfg_y(cfg_y), .cfg_vx(cfg_vx), .cfg_vy(cfg_vy),
    .cfg_color(cfg_color), .cfg_en(cfg_en), .rd_idx(rd_idx), .rd_x(rd_x), .rd_y(rd_y),
    .rd_color(rd_color), .busy(busy), .done(done), .overrun(overrun)
  );

  ball_scheduler #(.NUM_OBJ(4), .X_MAX(255), .Y_MAX(100)) dut_b (
    .clk(clk), .rst(rst), .frame_tick(frame_tick), .cfg_we(cfg_we), .cfg_ready(cfg_ready_b),
    .cfg_idx(cfg_idx), .cfg_x(cfg_x), .cfg_y(cfg_y), .cfg_vx(cfg_vx), .cfg_vy(cfg_vy),
    .cfg_color(cfg_color), .cfg_en(cfg_en), .rd_idx(rd_idx), .rd_x(rd_x_b), .rd_y(rd_y_b),
    .rd_color(rd_color_b), .busy(busy_b), .done(done_b), .overrun(overrun_b)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic setCfg(input logic [1:0] idx, input logic [7:0] x, input logic [6:0] y,
                        input logic vx, input logic vy, input logic [11:0] color, input logic en);
    cfg_idx   = idx;
    cfg_x     = x;
    cfg_y     = y;
    cfg_vx    = vx;
    cfg_vy    = vy;
    cfg_color = color;
    cfg_en    = en;
  endtask

  task automatic applyStimulus(input logic [1:0] idx, input logic [7:0] x, input logic [6:0] y,
                               input logic vx, input logic vy, input logic [11:0] color, input logic en);
    setCfg(idx, x, y, vx, vy, color, en);
    cfg_we = 1'b1;
    tick();
    cfg_we = 1'b0;
  endtask

  task automatic waitDone();
    int n = 0;
    while (done !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    checkOutput("pass_done", {31'd0, done}, 32'd1);
    tick();
  endtask

  task automatic runPass();
    frame_tick = 1'b1;
    tick();
    frame_tick = 1'b0;
    waitDone();
  endtask

  task automatic checkSlot(input string tag, input logic [1:0] idx,
                           input logic [7:0] ex, input logic [6:0] ey, input logic [11:0] ec);
    rd_idx = idx;
    tick();
    checkOutput($sformatf("%s_x", tag), {24'd0, rd_x}, {24'd0, ex});
    checkOutput($sformatf("%s_y", tag), {25'd0, rd_y}, {25'd0, ey});
    checkOutput($sformatf("%s_color", tag), {20'd0, rd_color}, {20'd0, ec});
  endtask

  initial begin
    int hi;
    rst = 1'b1; frame_tick = 1'b0; cfg_we = 1'b0; rd_idx = 2'd0;
    setCfg(2'd0, 8'd0, 7'd0, 1'b0, 1'b0, 12'd0, 1'b0);

    // Reset state
    tick();
    checkOutput("rst_rd_x", {24'd0, rd_x}, 32'd0);
    checkOutput("rst_rd_color", {20'd0, rd_color}, 32'd0);
    checkOutput("rst_busy", {31'd0, busy}, 32'd0);
    checkOutput("rst_done", {31'd0, done}, 32'd0);
    checkOutput("rst_overrun", {31'd0, overrun}, 32'd0);
    checkOutput("rst_ready", {31'd0, cfg_ready}, 32'd1);
    rst = 1'b0;
    checkSlot("rst_slot0", 2'd0, 8'd1, 7'd1, 12'd0);

    // T1: one pass from reset, busy for 4 cycles then a 1-cycle done
    frame_tick = 1'b1;
    tick();
    frame_tick = 1'b0;
    for (int k = 0; k < 4; k++) begin
      checkOutput($sformatf("t1_busy%0d", k), {31'd0, busy}, 32'd1);
      checkOutput($sformatf("t1_nodone%0d", k), {31'd0, done}, 32'd0);
      tick();
    end
    checkOutput("t1_busy_end", {31'd0, busy}, 32'd0);
    checkOutput("t1_done", {31'd0, done}, 32'd1);
    tick();
    checkOutput("t1_done_clr", {31'd0, done}, 32'd0);
    checkOutput("t1_ready", {31'd0, cfg_ready}, 32'd1);
    for (int s = 0; s < 4; s++) checkSlot($sformatf("t1_slot%0d", s), 2'(s), 8'd2, 7'd2, 12'd1);
    checkOutput("t1_overrun", {31'd0, overrun}, 32'd0);

    // T2: right wall and left wall bounces, plus color wrap
    applyStimulus(2'd0, 8'd255, 7'd10, 1'b1, 1'b1, 12'h100, 1'b1);
    runPass();
    checkSlot("t2_wall_r", 2'd0, 8'd254, 7'd11, 12'h101);
    runPass();
    checkSlot("t2_after_r", 2'd0, 8'd253, 7'd12, 12'h102);
    applyStimulus(2'd0, 8'd0, 7'd0, 1'b0, 1'b0, 12'hFFF, 1'b1);
    runPass();
    checkSlot("t2_wall_l", 2'd0, 8'd1, 7'd1, 12'h000);
    runPass();
    checkSlot("t2_after_l", 2'd0, 8'd2, 7'd2, 12'h001);

    // T3: bottom wall, and clamping on the Y_MAX=100 instance
    applyStimulus(2'd1, 8'd5, 7'd127, 1'b1, 1'b1, 12'h0A0, 1'b1);
    rd_idx = 2'd1;
    tick();
    checkOutput("t3_y_full", {25'd0, rd_y}, 32'd127);
    checkOutput("t3_y_clamp", {25'd0, rd_y_b}, 32'd100);
    runPass();
    rd_idx = 2'd1;
    tick();
    checkOutput("t3_y_bounce", {25'd0, rd_y}, 32'd126);
    checkOutput("t3_y_bounce_b", {25'd0, rd_y_b}, 32'd99);
    checkOutput("t3_x", {24'd0, rd_x}, 32'd6);
    runPass();
    rd_idx = 2'd1;
    tick();
    checkOutput("t3_y_down", {25'd0, rd_y}, 32'd125);
    checkOutput("t3_y_down_b", {25'd0, rd_y_b}, 32'd98);

    // T4: a second tick mid-pass is dropped and sets the sticky overrun
    applyStimulus(2'd2, 8'd50, 7'd50, 1'b1, 1'b1, 12'h010, 1'b1);
    frame_tick = 1'b1;
    tick();
    frame_tick = 1'b0;
    tick();
    frame_tick = 1'b1;
    tick();
    frame_tick = 1'b0;
    checkOutput("t4_overrun", {31'd0, overrun}, 32'd1);
    waitDone();
    hi = 0;
    for (int k = 0; k < 6; k++) begin
      if (busy === 1'b1) hi++;
      tick();
    end
    checkOutput("t4_not_queued", 32'(hi), 32'd0);
    checkOutput("t4_overrun_sticky", {31'd0, overrun}, 32'd1);
    checkSlot("t4_once", 2'd2, 8'd51, 7'd51, 12'h011);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checkOutput("t4_overrun_rst", {31'd0, overrun}, 32'd0);

    // T5: disabled slot stays frozen; a write during UPDATE is dropped
    applyStimulus(2'd2, 8'd30, 7'd40, 1'b1, 1'b1, 12'h555, 1'b0);
    frame_tick = 1'b1;
    tick();
    frame_tick = 1'b0;
    setCfg(2'd3, 8'd200, 7'd100, 1'b0, 1'b0, 12'hABC, 1'b1);
    cfg_we = 1'b1;
    checkOutput("t5_ready_low", {31'd0, cfg_ready}, 32'd0);
    tick();
    cfg_we = 1'b0;
    waitDone();
    checkSlot("t5_frozen", 2'd2, 8'd30, 7'd40, 12'h555);
    checkSlot("t5_dropped", 2'd3, 8'd2, 7'd2, 12'h001);

    // T5b: write and tick in the same IDLE cycle; the pass sees the new value
    setCfg(2'd1, 8'd100, 7'd20, 1'b1, 1'b0, 12'h7FF, 1'b1);
    cfg_we = 1'b1;
    frame_tick = 1'b1;
    tick();
    cfg_we = 1'b0;
    frame_tick = 1'b0;
    waitDone();
    checkSlot("t5_same_cycle", 2'd1, 8'd101, 7'd19, 12'h800);

    // T6: reset in the middle of a pass aborts it with no done pulse
    frame_tick = 1'b1;
    tick();
    frame_tick = 1'b0;
    tick();
    tick();
    checkOutput("t6_busy_mid", {31'd0, busy}, 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checkOutput("t6_busy", {31'd0, busy}, 32'd0);
    checkOutput("t6_ready", {31'd0, cfg_ready}, 32'd1);
    hi = 0;
    for (int k = 0; k < 6; k++) begin
      if (done === 1'b1) hi++;
      tick();
    end
    checkOutput("t6_no_done", 32'(hi), 32'd0);
    checkSlot("t6_slot0", 2'd0, 8'd1, 7'd1, 12'd0);
    checkSlot("t6_slot1", 2'd1, 8'd1, 7'd1, 12'd0);
    checkSlot("t6_slot2", 2'd2, 8'd1, 7'd1, 12'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
